vga_pattern_gen: RTL and testbench
==================================

// Module: vga_pattern_gen
// PURPOSE
//  Pixel-generation stage fed directly by the 640x480 VGA sync generator.
//  Consumes its pixel tick, counters, video_on and active-low syncs.
//  Produces 12-bit RGB (4:4:4) from a selectable test pattern, including a bouncing box.
//  Re-times the syncs through the same 2-stage pipeline so RGB and syncs stay aligned at the DAC.
// PARAMETERS
//  HD        640  visible width in pixels
//  VD        480  visible height in lines
//  BOX_W     32   bouncing box side, pixels (BOX_W < VD)
//  BOX_STEP  2    box displacement per frame, pixels, each axis
// PORTS
//  clk        in   1   system clock, same as the sync generator
//  reset_n    in   1   asynchronous, active-low reset
//  p_tick     in   1   pixel enable, 1 clk wide, every 2nd clk
//  video_on   in   1   upstream visible-area flag
//  hsync_in   in   1   upstream hsync, active-low
//  vsync_in   in   1   upstream vsync, active-low
//  pixel_x    in   10  upstream horizontal count 0..799
//  pixel_y    in   10  upstream vertical count 0..524
//  mode       in   2   pattern select: 0 bars, 1 grid, 2 box, 3 grey
//  pause      in   1   1 = freeze box position
//  rgb        out  12  {R[3:0],G[3:0],B[3:0]}, registered
//  hsync_out  out  1   hsync delayed to match rgb, active-low
//  vsync_out  out  1   vsync delayed to match rgb, active-low
//  frame_tick out  1   1-clk pulse after last visible pixel of a frame
// BEHAVIOUR
//  Clock and reset:
//   - One clock: clk. reset_n is asynchronous and active-low.
//   - Reset values: rgb=0, hsync_out=1, vsync_out=1, frame_tick=0.
//   - Internal reset: stage-1 video_on=0, syncs=1; box bx=0, by=0; dx=+1, dy=+1; mode_reg=0.
//  Pipeline:
//   - All pipeline registers load only when p_tick=1; otherwise they hold.
//   - Stage 1 registers x, y, video_on, syncs and region flags (bar index, grid hit, box hit).
//   - Stage 2 registers rgb, hsync_out, vsync_out.
//   - Latency is exactly 2 p_ticks for rgb and both syncs, so they change on the same clk edge.
//  Blanking: rgb=0 whenever the stage-aligned video_on=0. This overrides every mode.
//  frame_tick:
//   - Asserted one clk after a clk with p_tick & pixel_x==HD-1 & pixel_y==VD-1.
//   - Exactly one pulse per frame.
//  Mode latching: mode_reg<=mode on frame_tick only. A mid-frame change therefore never tears the image.
//  Patterns (current pixel x,y; mode_reg):
//   - 0 bars: 8 bars of HD/8=80 px. Bar index comes from a comparator chain, no divider.
//     Colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
//   - 1 grid: FFF if x[4:0]==0 | y[4:0]==0 | x==HD-1 | y==VD-1; else 000.
//   - 2 box: F00 if bx<=x<bx+BOX_W and by<=y<by+BOX_W; else 00F.
//   - 3 grey: 888 everywhere visible.
//  Box motion state machine (per axis, dir in {+,-}; updates on frame_tick when pause=0):
//   - +dir: n=pos+BOX_STEP. If n>=LIM then pos=LIM and dir=-; else pos=n. LIM=HD-BOX_W (x) or VD-BOX_W (y).
//   - -dir: if pos<=BOX_STEP then pos=0 and dir=+; else pos=pos-BOX_STEP.
//   - Compare in 11 bits so there is no wrap below 0 or above 1023.
//   - Both axes are independent. A corner hit flips both directions in the same update.
//   - pause=1 on frame_tick: position and direction hold.
//   - The box moves only between frames, never mid-scan.
//  Reset mid-frame: all state returns to its reset value at once.
//   - Outputs follow upstream again 2 p_ticks after reset_n deasserts.
//   - The first frame_tick comes at the next end of the visible area.
// TESTING
//  1. Assert reset_n=0 mid-line -> immediately rgb=0, hsync_out=1, vsync_out=1, frame_tick=0.
//  2. Mode 0, scan line y=10 -> rgb=FFF for x 0..79, FF0 for 80..159, ..., 000 for 560..639, 0 in blanking.
//     Each value appears 2 p_ticks after its pixel_x.
//  3. Upstream hsync low for x 656..751 -> hsync_out low for exactly 96 p_ticks, starting 2 p_ticks later.
//  4. Mode 2 from reset -> box at (0,0) in frame 1, at (2,2) after the first frame_tick.
//     After 304 frame_ticks bx=608 and dx flips to -; the next frame gives bx=606.
//  5. Force bx=607, +dir -> bx=608 (clamped), dir=-. Force bx=1, -dir -> bx=0, dir=+.
//     Both axes at a corner flip in the same frame.
//  6. Change mode 0->1 mid-frame -> pattern changes only after the next frame_tick.
//     pause=1 -> bx,by constant across 3 frame_ticks.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// Pixel stage behind the 640x480 sync generator: pattern colour plus sync re-timing
// through a 2-deep p_tick pipeline, and a bouncing box that moves once per frame.
module vga_pattern_gen #(
  parameter int HD       = 640,
  parameter int VD       = 480,
  parameter int BOX_W    = 32,
  parameter int BOX_STEP = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [1:0]  mode,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick,
  output logic [9:0]  dbg_bx,
  output logic [9:0]  dbg_by,
  output logic        dbg_dx_neg,
  output logic        dbg_dy_neg
);

  localparam logic [10:0] LIM_X  = 11'(HD - BOX_W);
  localparam logic [10:0] LIM_Y  = 11'(VD - BOX_W);
  localparam logic [10:0] STEP   = 11'(BOX_STEP);
  localparam logic [10:0] BW     = 11'(BOX_W);
  localparam logic [9:0]  X_LAST = 10'(HD - 1);
  localparam logic [9:0]  Y_LAST = 10'(VD - 1);
  localparam logic [9:0]  BAR1   = 10'(1 * (HD / 8));
  localparam logic [9:0]  BAR2   = 10'(2 * (HD / 8));
  localparam logic [9:0]  BAR3   = 10'(3 * (HD / 8));
  localparam logic [9:0]  BAR4   = 10'(4 * (HD / 8));
  localparam logic [9:0]  BAR5   = 10'(5 * (HD / 8));
  localparam logic [9:0]  BAR6   = 10'(6 * (HD / 8));
  localparam logic [9:0]  BAR7   = 10'(7 * (HD / 8));

  typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_t;

  logic [9:0]  r_bx, r_by;
  dir_t        r_dx, r_dy;
  logic [1:0]  r_mode;
  logic        r_frame_tick;

  logic        r_s1_von, r_s1_hs, r_s1_vs, r_s1_grid, r_s1_box;
  logic [2:0]  r_s1_bar;
  logic [1:0]  r_s1_mode;

  logic [11:0] r_rgb;
  logic        r_hs, r_vs;

  logic [2:0]  w_bar;
  logic        w_grid, w_box;
  logic [10:0] w_px, w_py, w_bx, w_by;
  logic [10:0] w_x_next, w_y_next;
  logic [11:0] w_color;

  // Returns {dir_is_neg, new_pos}; 11-bit arithmetic keeps both bounds wrap-free.
  function automatic logic [10:0] axis_next(input logic [9:0] pos, input dir_t dir,
                                            input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] n;
    p = {1'b0, pos};
    n = p + STEP;
    if (dir == DIR_POS) begin
      if (n >= lim) axis_next = {1'b1, lim[9:0]};
      else          axis_next = {1'b0, n[9:0]};
    end else begin
      n = p - STEP;
      if (p <= STEP) axis_next = 11'd0;
      else           axis_next = {1'b1, n[9:0]};
    end
  endfunction

  assign w_px     = {1'b0, pixel_x};
  assign w_py     = {1'b0, pixel_y};
  assign w_bx     = {1'b0, r_bx};
  assign w_by     = {1'b0, r_by};
  assign w_x_next = axis_next(r_bx, r_dx, LIM_X);
  assign w_y_next = axis_next(r_by, r_dy, LIM_Y);

  always_comb begin
    w_bar = 3'd7;
    if      (pixel_x < BAR1) w_bar = 3'd0;
    else if (pixel_x < BAR2) w_bar = 3'd1;
    else if (pixel_x < BAR3) w_bar = 3'd2;
    else if (pixel_x < BAR4) w_bar = 3'd3;
    else if (pixel_x < BAR5) w_bar = 3'd4;
    else if (pixel_x < BAR6) w_bar = 3'd5;
    else if (pixel_x < BAR7) w_bar = 3'd6;
  end

  assign w_grid = (pixel_x[4:0] == 5'd0) || (pixel_y[4:0] == 5'd0) ||
                  (pixel_x == X_LAST) || (pixel_y == Y_LAST);
  assign w_box  = (w_px >= w_bx) && (w_px < w_bx + BW) &&
                  (w_py >= w_by) && (w_py < w_by + BW);

  always_comb begin
    w_color = 12'h000;
    case (r_s1_mode)
      2'd0: begin
        case (r_s1_bar)
          3'd0:    w_color = 12'hFFF;
          3'd1:    w_color = 12'hFF0;
          3'd2:    w_color = 12'h0FF;
          3'd3:    w_color = 12'h0F0;
          3'd4:    w_color = 12'hF0F;
          3'd5:    w_color = 12'hF00;
          3'd6:    w_color = 12'h00F;
          default: w_color = 12'h000;
        endcase
      end
      2'd1:    w_color = r_s1_grid ? 12'hFFF : 12'h000;
      2'd2:    w_color = r_s1_box  ? 12'hF00 : 12'h00F;
      default: w_color = 12'h888;
    endcase
    if (!r_s1_von) w_color = 12'h000;
  end

  // Mode travels with the pixel through stage 1 so the last pixel of a frame
  // is not recoloured by the mode_reg update that its own frame_tick triggers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_von  <= 1'b0;
      r_s1_hs   <= 1'b1;
      r_s1_vs   <= 1'b1;
      r_s1_bar  <= 3'd0;
      r_s1_grid <= 1'b0;
      r_s1_box  <= 1'b0;
      r_s1_mode <= 2'd0;
      r_rgb     <= 12'h000;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
    end else if (p_tick) begin
      r_s1_von  <= video_on;
      r_s1_hs   <= hsync_in;
      r_s1_vs   <= vsync_in;
      r_s1_bar  <= w_bar;
      r_s1_grid <= w_grid;
      r_s1_box  <= w_box;
      r_s1_mode <= r_mode;
      r_rgb     <= w_color;
      r_hs      <= r_s1_hs;
      r_vs      <= r_s1_vs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_tick <= 1'b0;
      r_mode       <= 2'd0;
    end else begin
      r_frame_tick <= p_tick && (pixel_x == X_LAST) && (pixel_y == Y_LAST);
      if (r_frame_tick) r_mode <= mode;
    end
  end

  // Box motion: per-axis direction state, stepped once per frame_tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bx <= 10'd0;
      r_by <= 10'd0;
      r_dx <= DIR_POS;
      r_dy <= DIR_POS;
    end else if (r_frame_tick && !pause) begin
      r_bx <= w_x_next[9:0];
      r_dx <= dir_t'(w_x_next[10]);
      r_by <= w_y_next[9:0];
      r_dy <= dir_t'(w_y_next[10]);
    end
  end

  assign rgb        = r_rgb;
  assign hsync_out  = r_hs;
  assign vsync_out  = r_vs;
  assign frame_tick = r_frame_tick;
  assign dbg_bx     = r_bx;
  assign dbg_by     = r_by;
  assign dbg_dx_neg = (r_dx == DIR_NEG);
  assign dbg_dy_neg = (r_dy == DIR_NEG);

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: the bench acts as the sync generator and
// drives pixels one p_tick at a time; expected values are hand-derived constants.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_tick = 1'b0;
  logic        video_on = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [9:0]  pixel_x = 10'd0;
  logic [9:0]  pixel_y = 10'd0;
  logic [1:0]  mode = 2'd0;
  logic        pause = 1'b0;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, frame_tick;
  logic [9:0]  dbg_bx, dbg_by;
  logic        dbg_dx_neg, dbg_dy_neg;

  int n_assert = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] bar_rgb [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

  vga_pattern_gen dut (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .mode(mode), .pause(pause), .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .frame_tick(frame_tick), .dbg_bx(dbg_bx),
    .dbg_by(dbg_by), .dbg_dx_neg(dbg_dx_neg), .dbg_dy_neg(dbg_dy_neg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel with a single-clk p_tick; returns at the negedge after the p_tick edge.
  task automatic pix(input int x, input int y, input logic von, input logic hs, input logic vs);
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    p_tick   = 1'b1;
    @(negedge clk);
    p_tick   = 1'b0;
  endtask

  task automatic vis(input int x, input int y);
    pix(x, y, 1'b1, 1'b1, 1'b1);
  endtask

  // Pixel (x,y) reaches rgb after the next pixel's p_tick.
  task automatic px_check(input string tag, input int x, input int y, input logic [11:0] exp);
    vis(x, y);
    vis(x + 1, y);
    check(tag, rgb, exp);
  endtask

  // Last visible pixel, then let the frame_tick-triggered updates settle.
  task automatic fast_frame();
    vis(639, 479);
    @(negedge clk);
  endtask

  initial begin
    int hs_low;
    int hs_first;
    logic [11:0] e;

    // reset
    repeat (3) @(negedge clk);
    check("rst_rgb", rgb, 12'h000);
    check("rst_hs", hsync_out, 1'b1);
    check("rst_vs", vsync_out, 1'b1);
    check("rst_ft", frame_tick, 1'b0);
    check("rst_bx", dbg_bx, 10'd0);
    check("rst_by", dbg_by, 10'd0);
    check("rst_dx", dbg_dx_neg, 1'b0);
    check("rst_dy", dbg_dy_neg, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // mode 0, full line y=10 through the scoreboard queue
    hs_low   = 0;
    hs_first = -1;
    exp_q.push_back(12'h000);
    for (int x = 0; x < 800; x++) begin
      pix(x, 10, (x < 640), !(x >= 656 && x < 752), 1'b1);
      e = exp_q.pop_front();
      check("bars_line", rgb, e);
      if (!hsync_out) begin
        hs_low++;
        if (hs_first < 0) hs_first = x;
      end
      exp_q.push_back((x < 640) ? bar_rgb[x / 80] : 12'h000);
    end
    check("hs_low_len", hs_low, 96);
    check("hs_low_start", hs_first, 657);
    check("line_vs", vsync_out, 1'b1);

    // mode change mid-frame waits for frame_tick
    mode = 2'd1;
    px_check("mode_hold", 100, 11, 12'hFF0);
    vis(639, 478);
    check("ft_not_478", frame_tick, 1'b0);
    vis(639, 479);
    check("ft_pulse", frame_tick, 1'b1);
    @(negedge clk);
    check("ft_one_clk", frame_tick, 1'b0);
    px_check("grid_off", 100, 11, 12'h000);
    px_check("grid_x32", 96, 11, 12'hFFF);
    px_check("grid_y32", 5, 32, 12'hFFF);
    px_check("grid_xlast", 639, 11, 12'hFFF);
    px_check("grid_ylast", 5, 479, 12'hFFF);
    px_check("grid_mid", 5, 11, 12'h000);

    // grey and blanking override
    mode = 2'd3;
    fast_frame();
    px_check("grey", 200, 50, 12'h888);
    pix(700, 50, 1'b0, 1'b1, 1'b1);
    pix(701, 50, 1'b0, 1'b1, 1'b1);
    check("blank_grey", rgb, 12'h000);

    // asynchronous reset mid-line
    vis(300, 50);
    pix(656, 50, 1'b1, 1'b0, 1'b0);
    pix(657, 50, 1'b1, 1'b0, 1'b0);
    check("pre_rst_rgb", rgb, 12'h888);
    check("pre_rst_hs", hsync_out, 1'b0);
    check("pre_rst_vs", vsync_out, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_rgb", rgb, 12'h000);
    check("midrst_hs", hsync_out, 1'b1);
    check("midrst_vs", vsync_out, 1'b1);
    check("midrst_ft", frame_tick, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    vis(100, 20);
    check("post_rst_1", rgb, 12'h000);
    vis(101, 20);
    check("post_rst_2", rgb, 12'hFF0);

    // bouncing box: first frame_tick only latches the mode
    mode  = 2'd2;
    pause = 1'b1;
    fast_frame();
    check("box0_bx", dbg_bx, 10'd0);
    check("box0_by", dbg_by, 10'd0);
    px_check("box0_in00", 0, 0, 12'hF00);
    px_check("box0_in31", 31, 31, 12'hF00);
    px_check("box0_outx", 32, 0, 12'h00F);
    px_check("box0_outy", 0, 32, 12'h00F);
    pause = 1'b0;
    fast_frame();
    check("box1_bx", dbg_bx, 10'd2);
    check("box1_by", dbg_by, 10'd2);
    px_check("box1_out11", 1, 1, 12'h00F);
    px_check("box1_in22", 2, 2, 12'hF00);
    px_check("box1_in33", 33, 33, 12'hF00);
    px_check("box1_out34", 34, 10, 12'h00F);

    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fast_frame();
      check("pause_bx", dbg_bx, 10'd2);
      check("pause_by", dbg_by, 10'd2);
      check("pause_dx", dbg_dx_neg, 1'b0);
    end
    pause = 1'b0;

    for (int t = 2; t <= 8513; t++) begin
      fast_frame();
      if (t == 224) begin
        check("t224_by", dbg_by, 10'd448);
        check("t224_dy", dbg_dy_neg, 1'b1);
        check("t224_bx", dbg_bx, 10'd448);
      end
      if (t == 225) begin
        check("t225_by", dbg_by, 10'd446);
        check("t225_bx", dbg_bx, 10'd450);
      end
      if (t == 304) begin
        check("t304_bx", dbg_bx, 10'd608);
        check("t304_dx", dbg_dx_neg, 1'b1);
        check("t304_by", dbg_by, 10'd288);
      end
      if (t == 305) begin
        check("t305_bx", dbg_bx, 10'd606);
        check("t305_by", dbg_by, 10'd286);
      end
      if (t == 448) begin
        check("t448_by", dbg_by, 10'd0);
        check("t448_dy", dbg_dy_neg, 1'b0);
        check("t448_bx", dbg_bx, 10'd320);
      end
      if (t == 608) begin
        check("t608_bx", dbg_bx, 10'd0);
        check("t608_dx", dbg_dx_neg, 1'b0);
        check("t608_by", dbg_by, 10'd320);
      end
      if (t == 8511) begin
        check("t8511_bx", dbg_bx, 10'd2);
        check("t8511_by", dbg_by, 10'd2);
        check("t8511_dx", dbg_dx_neg, 1'b1);
        check("t8511_dy", dbg_dy_neg, 1'b1);
      end
      if (t == 8512) begin
        check("corner_bx", dbg_bx, 10'd0);
        check("corner_by", dbg_by, 10'd0);
        check("corner_dx", dbg_dx_neg, 1'b0);
        check("corner_dy", dbg_dy_neg, 1'b0);
      end
      if (t == 8513) begin
        check("t8513_bx", dbg_bx, 10'd2);
        check("t8513_by", dbg_by, 10'd2);
      end
    end
    px_check("box_end_in", 3, 3, 12'hF00);

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
